// File: rtl/alu_sequencer.sv
// Execute-stage sequencer for the external 16-bit ALU: operand handshake, flag register,
// branch resolution and two-pass 32-bit ADD. Define ALU_SEQ_STAT_EN for completion counters.
module alu_sequencer #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_func,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [WIDTH-1:0]  in_a_hi,
  input  logic [WIDTH-1:0]  in_b_hi,
  input  logic              in_wide,
  input  logic              in_flag_en,
  output logic [3:0]        alu_func,
  output logic [WIDTH-1:0]  alu_op0,
  output logic [WIDTH-1:0]  alu_op1,
  output logic              alu_flag_en,
  output logic [3:0]        alu_flag_in,
  input  logic [WIDTH-1:0]  alu_q,
  input  logic [3:0]        alu_flag_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_q,
  output logic [WIDTH-1:0]  out_q_hi,
  output logic              out_taken,
  output logic [3:0]        flags,
  output logic [STAT_W-1:0] stat_ops,
  output logic [STAT_W-1:0] stat_taken
);

  typedef enum logic [1:0] {IDLE, EXEC, EXEC_HI, DONE} state_t;

  typedef enum logic [3:0] {
    F_JMP = 4'h0, F_ADD = 4'h1, F_SUB = 4'h2, F_LSL = 4'h3,
    F_LSR = 4'h4, F_AND = 4'h5, F_OR  = 4'h6, F_XOR = 4'h7,
    F_LD  = 4'h8, F_ST  = 4'h9, F_MOV = 4'hA, F_BEQ = 4'hB,
    F_BNE = 4'hC, F_BLT = 4'hD, F_BGT = 4'hE, F_CMP = 4'hF
  } func_t;

  state_t           state, state_nx;
  func_t            func_r;
  logic [WIDTH-1:0] a_r, b_r, a_hi_r, b_hi_r;
  logic             wide_r, fen_r, lo_c;

  logic             accept;
  logic             pass_flag_en;
  logic             is_shift, shift_big, shift_zero;
  logic             taken;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       res_flags;

  assign accept = in_valid && in_ready;

  // Operand/func capture; datapath registers need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      func_r <= func_t'(in_func);
      a_r    <= in_a;
      b_r    <= in_b;
      a_hi_r <= in_a_hi;
      b_hi_r <= in_b_hi;
      wide_r <= in_wide && (in_func == F_ADD);
      fen_r  <= in_flag_en;
    end
  end

  always_comb begin
    pass_flag_en = 1'b0;
    if (func_r inside {F_ADD, F_SUB, F_LSL, F_LSR, F_AND, F_OR, F_XOR})
      pass_flag_en = fen_r;
    else if (func_r == F_CMP)
      pass_flag_en = 1'b1;
  end

  // Branch decision reads the architectural flags, never the ALU result.
  always_comb begin
    taken = 1'b0;
    case (func_r)
      F_JMP:   taken = 1'b1;
      F_BEQ:   taken = flags[0];
      F_BNE:   taken = !flags[0];
      F_BLT:   taken = flags[2] && !flags[0];
      F_BGT:   taken = !flags[2] && !flags[0];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    is_shift   = (func_r == F_LSL) || (func_r == F_LSR);
    shift_big  = |b_r[WIDTH-1:4];
    shift_zero = (b_r == '0);
    res_q      = alu_q;
    res_flags  = alu_flag_out;
    if (func_r inside {F_JMP, F_BEQ, F_BNE, F_BLT, F_BGT}) begin
      res_q = taken ? a_r : b_r;
    end else if (is_shift && shift_big) begin
      res_q     = '0;
      res_flags = 4'b0001;
    end else if (is_shift && shift_zero) begin
      res_q     = a_r;
      res_flags = {1'b0, a_r[WIDTH-1], 1'b0, (a_r == '0)};
    end
  end

  always_comb begin
    state_nx    = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    alu_func    = '0;
    alu_op0     = '0;
    alu_op1     = '0;
    alu_flag_en = 1'b0;
    alu_flag_in = '0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) state_nx = EXEC;
      end
      EXEC: begin
        alu_func    = func_r;
        alu_op0     = a_r;
        alu_op1     = b_r;
        alu_flag_en = pass_flag_en;
        alu_flag_in = {1'b0, flags[2:0]};
        state_nx    = wide_r ? EXEC_HI : DONE;
      end
      EXEC_HI: begin
        alu_func    = F_ADD;
        alu_op0     = a_hi_r;
        alu_op1     = b_hi_r;
        alu_flag_en = fen_r;
        alu_flag_in = {lo_c, flags[2:0]};
        state_nx    = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flags     <= '0;
      out_q     <= '0;
      out_q_hi  <= '0;
      out_taken <= 1'b0;
      lo_c      <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        EXEC: begin
          out_q     <= res_q;
          out_q_hi  <= '0;
          out_taken <= taken;
          lo_c      <= alu_flag_out[3];
          if (!wide_r && alu_flag_en) flags <= res_flags;
        end
        EXEC_HI: begin
          out_q_hi <= alu_q;
          // Wide Z must span both halves; the ALU only sees the high word.
          if (alu_flag_en) flags <= {alu_flag_out[3:1], (out_q == '0) && (alu_q == '0)};
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_STAT_EN
  logic [STAT_W-1:0] ops_cnt, taken_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_cnt   <= '0;
      taken_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (ops_cnt != '1) ops_cnt <= ops_cnt + 1'b1;
      if (out_taken && (taken_cnt != '1)) taken_cnt <= taken_cnt + 1'b1;
    end
  end

  assign stat_ops   = ops_cnt;
  assign stat_taken = taken_cnt;
`else
  assign stat_ops   = '0;
  assign stat_taken = '0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised self-checking bench for alu_sequencer with a behavioural ALU and an
// operation-level reference model of results, flags and branch outcomes.
module tb_alu_sequencer;

  localparam logic [3:0] F_JMP = 4'h0, F_ADD = 4'h1, F_SUB = 4'h2, F_LSL = 4'h3,
                         F_LSR = 4'h4, F_AND = 4'h5, F_OR  = 4'h6, F_XOR = 4'h7,
                         F_BEQ = 4'hB, F_BNE = 4'hC, F_BLT = 4'hD, F_BGT = 4'hE,
                         F_CMP = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_func = '0;
  logic [15:0] in_a = '0, in_b = '0, in_a_hi = '0, in_b_hi = '0;
  logic        in_wide = 1'b0, in_flag_en = 1'b0;
  logic [3:0]  alu_func;
  logic [15:0] alu_op0, alu_op1;
  logic        alu_flag_en;
  logic [3:0]  alu_flag_in;
  logic [15:0] alu_q;
  logic [3:0]  alu_flag_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_q, out_q_hi;
  logic        out_taken;
  logic [3:0]  flags;
  logic [15:0] stat_ops, stat_taken;

  int unsigned n_tests = 0, n_fail = 0;
  logic [3:0]  ref_flags = '0;
  int unsigned ref_ops = 0, ref_taken = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(16), .STAT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
    .in_a(in_a), .in_b(in_b), .in_a_hi(in_a_hi), .in_b_hi(in_b_hi),
    .in_wide(in_wide), .in_flag_en(in_flag_en),
    .alu_func(alu_func), .alu_op0(alu_op0), .alu_op1(alu_op1),
    .alu_flag_en(alu_flag_en), .alu_flag_in(alu_flag_in),
    .alu_q(alu_q), .alu_flag_out(alu_flag_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_q_hi(out_q_hi), .out_taken(out_taken),
    .flags(flags), .stat_ops(stat_ops), .stat_taken(stat_taken)
  );

  // Stand-in ALU. Shift-by-0 carry and out-of-range shifts deliberately return junk
  // so the sequencer's overrides are observable.
  logic [16:0] alu_s;
  logic        alu_c, alu_v;
  logic [3:0]  alu_idx;
  always_comb begin
    alu_s   = '0;
    alu_q   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_idx = '0;
    case (alu_func)
      F_ADD: begin
        alu_s = {1'b0, alu_op0} + {1'b0, alu_op1} + {16'b0, alu_flag_in[3]};
        alu_q = alu_s[15:0];
        alu_c = alu_s[16];
        alu_v = (alu_op0[15] == alu_op1[15]) && (alu_q[15] != alu_op0[15]);
      end
      F_SUB, F_CMP: begin
        alu_q = alu_op0 - alu_op1;
        alu_c = alu_op0 < alu_op1;
        alu_v = (alu_op0[15] != alu_op1[15]) && (alu_q[15] != alu_op0[15]);
      end
      F_LSL: begin
        if (alu_op1 == 16'd0) begin alu_q = alu_op0; alu_c = 1'b1; end
        else if (alu_op1 < 16'd16) begin
          alu_idx = 4'd0 - alu_op1[3:0];
          alu_q   = alu_op0 << alu_op1;
          alu_c   = alu_op0[alu_idx];
        end else begin alu_q = ~alu_op0; alu_c = 1'b1; end
      end
      F_LSR: begin
        if (alu_op1 == 16'd0) begin alu_q = alu_op0; alu_c = 1'b1; end
        else if (alu_op1 < 16'd16) begin
          alu_idx = alu_op1[3:0] - 4'd1;
          alu_q   = alu_op0 >> alu_op1;
          alu_c   = alu_op0[alu_idx];
        end else begin alu_q = ~alu_op0; alu_c = 1'b1; end
      end
      F_AND: alu_q = alu_op0 & alu_op1;
      F_OR:  alu_q = alu_op0 | alu_op1;
      F_XOR: alu_q = alu_op0 ^ alu_op1;
      4'h8, 4'h9, 4'hA: alu_q = alu_op0;
      default: begin alu_q = alu_op1 ^ 16'h5A5A; alu_c = 1'b1; end
    endcase
  end
  assign alu_flag_out = {alu_c, alu_q[15], alu_v, (alu_q == 16'd0)};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Whole-operation model: results from integer arithmetic on the operand values.
  function automatic void ref_exec(input logic [3:0] f, input logic [15:0] a, b, ah, bh,
                                   input logic wide, fen, input logic [3:0] fl_in,
                                   output logic [3:0] fl_out, output logic [15:0] q, qh,
                                   output logic tk);
    int sd;
    longint sl;
    int unsigned u;
    longint unsigned ul;
    logic c, n, v, z, upd, cond;
    q = '0; qh = '0; tk = 1'b0; c = 1'b0; v = 1'b0; cond = 1'b0;
    upd = (f >= F_ADD && f <= F_XOR) ? fen : (f == F_CMP);
    case (f)
      F_JMP: begin q = a; tk = 1'b1; end
      F_ADD: begin
        if (wide) begin
          ul = 64'({ah, a}) + 64'({bh, b});
          q  = ul[15:0];
          qh = ul[31:16];
          c  = ul[32];
          sl = longint'($signed({ah, a})) + longint'($signed({bh, b}));
          v  = (sl > 64'sd2147483647) || (sl < -64'sd2147483648);
        end else begin
          u  = 32'(a) + 32'(b);
          q  = u[15:0];
          c  = u[16];
          sd = int'($signed(a)) + int'($signed(b));
          v  = (sd > 32767) || (sd < -32768);
        end
      end
      F_SUB, F_CMP: begin
        q  = a - b;
        c  = a < b;
        sd = int'($signed(a)) - int'($signed(b));
        v  = (sd > 32767) || (sd < -32768);
      end
      F_LSL: if (b <= 16'd15) begin
        u = 32'(a) << b;
        q = u[15:0];
        c = (b != 16'd0) && u[16];
      end
      F_LSR: if (b <= 16'd15) begin
        q = a >> b;
        u = 32'(a) >> (b - 16'd1);
        c = (b != 16'd0) && u[0];
      end
      F_AND: q = a & b;
      F_OR:  q = a | b;
      F_XOR: q = a ^ b;
      F_BEQ, F_BNE, F_BLT, F_BGT: begin
        case (f)
          F_BEQ:   cond = fl_in[0];
          F_BNE:   cond = !fl_in[0];
          F_BLT:   cond = fl_in[2] && !fl_in[0];
          default: cond = !fl_in[2] && !fl_in[0];
        endcase
        q  = cond ? a : b;
        tk = cond;
      end
      default: q = a;
    endcase
    n = wide ? qh[15] : q[15];
    z = wide ? ({qh, q} == 32'd0) : (q == 16'd0);
    fl_out = upd ? {c, n, v, z} : fl_in;
  endfunction

  function automatic logic [31:0] exp_stat(input int unsigned cnt);
`ifdef ALU_SEQ_STAT_EN
    return (cnt > 32'hFFFF) ? 32'hFFFF : cnt;
`else
    return (cnt == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic run_op(input logic [3:0] f, input logic [15:0] a, b, ah, bh,
                        input logic wide, fen, input int unsigned hold);
    logic [3:0]  ef;
    logic [15:0] eq, eqh;
    logic        etk, we;
    int unsigned n, u;
    we = wide && (f == F_ADD);
    ref_exec(f, a, b, ah, bh, we, fen, ref_flags, ef, eq, eqh, etk);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    out_ready  = 1'($urandom_range(0, 1));
    in_func    = f; in_a = a; in_b = b; in_a_hi = ah; in_b_hi = bh;
    in_wide    = wide; in_flag_en = fen; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_func = 4'($urandom); in_a = 16'($urandom); in_b = 16'($urandom);
    in_a_hi = 16'($urandom); in_b_hi = 16'($urandom);
    in_wide = 1'($urandom); in_flag_en = 1'($urandom);
    check("exec_func", 32'(alu_func), 32'(f));
    check("exec_op0", 32'(alu_op0), 32'(a));
    check("exec_op1", 32'(alu_op1), 32'(b));
    check("exec_flag_in", 32'(alu_flag_in), 32'({1'b0, ref_flags[2:0]}));
    check("exec_flag_en", 32'(alu_flag_en),
          32'((f >= F_ADD && f <= F_XOR) ? fen : (f == F_CMP)));
    check("exec_not_ready", 32'(in_ready), 32'd0);
    n = 1;
    if (we) begin
      @(negedge clk); out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
      u = 32'(a) + 32'(b);
      check("hi_func", 32'(alu_func), 32'(F_ADD));
      check("hi_op0", 32'(alu_op0), 32'(ah));
      check("hi_op1", 32'(alu_op1), 32'(bh));
      check("hi_flag_in", 32'(alu_flag_in), 32'({u[16], ref_flags[2:0]}));
      check("hi_flag_en", 32'(alu_flag_en), 32'(fen));
    end
    while (!out_valid && n < 12) begin
      @(negedge clk); out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    check("latency", n, we ? 32'd3 : 32'd2);
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_q", 32'(out_q), 32'(eq));
    check("out_q_hi", 32'(out_q_hi), 32'(eqh));
    check("out_taken", 32'(out_taken), 32'(etk));
    check("flags", 32'(flags), 32'(ef));
    check("done_not_ready", 32'(in_ready), 32'd0);
    ref_flags = ef;
    for (int unsigned i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_q", 32'(out_q), 32'(eq));
      check("hold_not_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    ref_ops++;
    if (etk) ref_taken++;
    check("released", 32'(out_valid), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd1);
    check("stat_ops", 32'(stat_ops), exp_stat(ref_ops));
    check("stat_taken", 32'(stat_taken), exp_stat(ref_taken));
  endtask

  initial begin
    logic [3:0]  f;
    logic [15:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_out_q", 32'({out_q_hi, out_q}), 32'd0);
    check("rst_out_taken", 32'(out_taken), 32'd0);
    check("rst_alu", 32'({alu_func, alu_flag_en, alu_flag_in}), 32'd0);
    check("rst_alu_ops", 32'({alu_op0, alu_op1}), 32'd0);
    check("rst_stat", 32'({stat_ops, stat_taken}), 32'd0);

    run_op(F_ADD, 16'h7FFF, 16'h0001, 16'h0, 16'h0, 1'b0, 1'b1, 0);
    check("add_ovf_q", 32'(out_q), 32'h8000);
    check("add_ovf_flags", 32'(flags), 32'b0110);
    run_op(F_CMP, 16'h1234, 16'h1234, 16'h0, 16'h0, 1'b0, 1'b0, 0);
    check("cmp_eq_flags", 32'(flags), 32'b0001);
    run_op(F_BEQ, 16'h0040, 16'h0012, 16'h0, 16'h0, 1'b0, 1'b1, 0);
    check("beq_q", 32'(out_q), 32'h0040);
    run_op(F_BNE, 16'h0040, 16'h0012, 16'h0, 16'h0, 1'b0, 1'b1, 0);
    check("bne_q", 32'(out_q), 32'h0012);
    run_op(F_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1, 0);
    check("wide_q", 32'({out_q_hi, out_q}), 32'h0001_0000);
    check("wide_flags", 32'(flags), 32'b0000);
    run_op(F_LSL, 16'h8001, 16'd0, 16'h0, 16'h0, 1'b0, 1'b1, 0);
    check("lsl0_flags", 32'(flags), 32'b0100);
    run_op(F_LSL, 16'h8001, 16'd20, 16'h0, 16'h0, 1'b0, 1'b1, 0);
    check("lsl20_flags", 32'(flags), 32'b0001);
    run_op(F_SUB, 16'h0003, 16'h0005, 16'h0, 16'h0, 1'b0, 1'b1, 5);
    run_op(F_XOR, 16'hAAAA, 16'h5555, 16'h0, 16'h0, 1'b1, 1'b1, 0);

    for (int unsigned k = 0; k < 250; k++) begin
      f = 4'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      if ((f == F_LSL || f == F_LSR) && ($urandom_range(0, 3) != 0)) b = 16'($urandom_range(0, 20));
      if ($urandom_range(0, 5) == 0) b = a;
      if ($urandom_range(0, 7) == 0) a = 16'h0000;
      run_op(f, a, b, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    run_op(F_CMP, 16'h0001, 16'h0002, 16'h0, 16'h0, 1'b0, 1'b0, 0);
    check("pre_rst_flags", 32'(flags), 32'b1100);
    @(negedge clk);
    in_func = F_ADD; in_a = 16'h1000; in_b = 16'h2000; in_wide = 1'b0;
    in_flag_en = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    ref_flags = '0; ref_ops = 0; ref_taken = 0;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_flags", 32'(flags), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_stat", 32'(stat_ops), exp_stat(ref_ops));
    @(negedge clk); rst = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    check("midrst_idle_ready", 32'(in_ready), 32'd1);
    run_op(F_ADD, 16'h0001, 16'h0001, 16'h0, 16'h0, 1'b0, 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Execute-stage controller that owns the combinational 16-bit ALU and sequences one operation at a time into it.
- Accepts decoded operations over a valid/ready handshake and holds registered operands on the ALU inputs.
- Maintains the architectural flag register (bit3 C, bit2 N, bit1 V, bit0 Z), resolves branch decisions, and chains two ALU passes for 32-bit wide ADD.
- Returns results over a valid/ready handshake.

Parameters:
- WIDTH, 16, datapath width. Only 16 is supported.
- STAT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  sequencer can accept
- in_func  in  4  ALU function code (0000 JMP … 1111 CMP)
- in_a  in  16  operand A; branch target for branches; low word for wide ops
- in_b  in  16  operand B; fall-through PC for branches
- in_a_hi  in  16  wide-op high word of A
- in_b_hi  in  16  wide-op high word of B
- in_wide  in  1  request 32-bit op (honoured for ADD only)
- in_flag_en  in  1  update flags (funcs 0001-0111)
- alu_func  out  4  to ALU func
- alu_op0  out  16  to ALU OP0
- alu_op1  out  16  to ALU OP1
- alu_flag_en  out  1  to ALU flag_en
- alu_flag_in  out  4  to ALU flag_in
- alu_q  in  16  from ALU Q
- alu_flag_out  in  4  from ALU flag_out
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_q  out  16  result or low word
- out_q_hi  out  16  wide high word; 0 otherwise
- out_taken  out  1  branch taken (branch funcs only)
- flags  out  4  architectural flag register
- stat_ops  out  STAT_W  completed ops (optional)
- stat_taken  out  STAT_W  taken branches (optional)

Behaviour:
- Reset: state IDLE; flags=0; out_valid=0; out_q=0; out_q_hi=0; out_taken=0; all alu_* outputs 0; in_ready=0 while rst is high.
- in_ready = (state==IDLE). Accept on in_valid & in_ready; operands and func are latched at that edge.
- State IDLE: accept → EXEC.
- State EXEC:
  - Drives alu_func, alu_op0=A_lo, alu_op1=B_lo.
  - alu_flag_in = {1'b0, flags[2:0]}. Carry-in is always 0 for the first pass.
  - alu_flag_en = in_flag_en for 0001-0111, 1 for CMP, 0 for all others.
  - Captures alu_q/alu_flag_out at the end of the cycle.
  - Next state: wide ADD → EXEC_HI; otherwise → DONE.
- State EXEC_HI:
  - Drives ADD with op0=A_hi, op1=B_hi, alu_flag_in[3]=low-pass carry.
  - Captures the result to out_q_hi. → DONE.
- State DONE: out_valid=1; outputs stable until out_valid & out_ready → IDLE. Back-to-back accept is not possible; minimum issue interval is 3 cycles (4 for wide).
- Latency: out_valid is asserted 2 cycles after the accept edge (3 for wide).
- Flag update: written at the final EXEC/EXEC_HI edge, only when alu_flag_en=1.
  - Wide ADD flags: C, V, N from the high pass; Z = (low==0)&(high==0).
  - LD/ST/MOV/JMP/branches never modify flags.
- Branches: decided from the flags register, not ALU Q.
  - BEQ: Z=1. BNE: Z=0. BLT: N=1&Z=0. BGT: N=0&Z=0.
  - out_q = taken ? in_a : in_b; out_taken set accordingly.
  - The ALU is still driven, but alu_q is ignored.
- JMP: out_q = in_a; out_taken=1.
- Shifts (0011, 0100):
  - in_b > 15: the ALU result is not used. out_q=0; if flagging, flags = C0 N0 V0 Z1.
  - in_b == 0: out_q = in_a; C forced 0, N/Z from in_a, V=0.
- in_wide with a non-ADD func is ignored; executes as 16-bit; out_q_hi=0.
- CMP: out_q = difference; flags always written.
- Reset mid-operation: in-flight op discarded; reset values apply on the next edge. A flag write coinciding with rst is lost.
- out_ready is ignored outside DONE.

Optional Feature:
- Macro: ALU_SEQ_STAT_EN.
- Defined: stat_ops increments on every out_valid & out_ready; stat_taken increments on those with out_taken=1. Both saturate at all-ones and clear on rst.
- Undefined: no counter logic; stat_ops and stat_taken are tied to 0.

Test Plan:
- ADD 0x7FFF+0x0001, in_flag_en=1 → out_q=0x8000, flags N=1 V=1 C=0 Z=0, out_valid 2 cycles after accept.
- CMP 0x1234,0x1234 then BEQ a=0x0040 b=0x0012 → Z=1, out_q=0x0040, out_taken=1. Then BNE → out_q=0x0012, out_taken=0.
- Wide ADD A=0x0000FFFF, B=0x00000001 → out_q=0x0000, out_q_hi=0x0001, Z=0 C=0, out_valid 3 cycles after accept.
- LSL a=0x8001, b=0 → out_q=0x8001, C=0. Then b=20 → out_q=0, Z=1.
- Hold out_ready=0 for 5 cycles in DONE → out_valid and out_q stable, in_ready=0. Then release → IDLE, in_ready=1.
- Assert rst during EXEC of ADD with flag_en → out_valid never asserts, flags=0. With ALU_SEQ_STAT_EN, stat_ops=0.
